// File: rtl/audio_score_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_rec_pkg
//  Description : Shared constants, FSM state type and width helper for the
//                audio template scoring front end (score accumulator and the
//                frame buffer it owns).
//  Contents    : X_W, T_W, I_W, D_W, FRAME_LEN, TPL_NUM defaults,
//                state_t {IDLE, FILL, CALC, ISSUE}, tid_width()
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_rec_pkg;

    localparam int FRAME_LEN = 512;  // bins per frame, power of 2
    localparam int TPL_NUM   = 8;    // templates scored per frame
    localparam int X_W       = 16;   // FFT magnitude width
    localparam int T_W       = 12;   // template weight width
    localparam int I_W       = 50;   // divider dividend width
    localparam int D_W       = 38;   // divider divisor width

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CALC  = 2'd2,
        ISSUE = 2'd3
    } state_t;

    // A single template still needs a 1-bit id field to stay a legal vector.
    function automatic int tid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_score_accum_frame_buf_ram.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buf_ram
//  Description : Simple dual-port frame buffer, one write port and one
//                registered read port (1-cycle read latency). Contents are
//                not reset.
//  Ports       : clk            clock
//                we/waddr/wdata write port
//                raddr          read address
//                rdata          read data, valid one cycle after raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_buf_ram #(
    parameter  int DEPTH = 512,
    parameter  int W     = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule
`default_nettype wire

// File: rtl/audio_score_accum.sv
`default_nettype none
// ============================================================================
//  Module      : audio_score_accum
//  Description : Buffers one FFT magnitude frame, then for every template k
//                computes num = sum(x*t) and den = sum(x) and hands one
//                {dividend, divisor} word per template to the score divider.
//  Ports       : clk, reset (async, active-low)
//                bin_valid/bin_data/bin_last/bin_ready  frame input
//                tpl_addr/tpl_data   template ROM, addr = {tpl_id, bin_idx},
//                                    1-cycle read latency
//                div_valid/div_dividend/div_divisor/div_tpl_id  divider feed
//                frame_done          pulse one cycle after the last issue
//                err_overrun         sticky, bin offered while not ready
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_score_accum #(
    parameter  int FRAME_LEN = audio_rec_pkg::FRAME_LEN,
    parameter  int TPL_NUM   = audio_rec_pkg::TPL_NUM,
    parameter  int X_W       = audio_rec_pkg::X_W,
    parameter  int T_W       = audio_rec_pkg::T_W,
    parameter  int I_W       = audio_rec_pkg::I_W,
    parameter  int D_W       = audio_rec_pkg::D_W,
    localparam int BIN_W     = $clog2(FRAME_LEN),
    localparam int AW        = $clog2(TPL_NUM * FRAME_LEN),
    localparam int TID_W     = audio_rec_pkg::tid_width(TPL_NUM)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bin_valid,
    input  logic [X_W-1:0]   bin_data,
    input  logic             bin_last,
    output logic             bin_ready,
    output logic [AW-1:0]    tpl_addr,
    input  logic [T_W-1:0]   tpl_data,
    output logic             div_valid,
    output logic [I_W-1:0]   div_dividend,
    output logic [D_W-1:0]   div_divisor,
    output logic [TID_W-1:0] div_tpl_id,
    output logic             frame_done,
    output logic             err_overrun
);

    import audio_rec_pkg::*;

    // bin_cnt must hold N == FRAME_LEN; calc_idx must reach N+2.
    localparam int CNT_W  = BIN_W + 1;
    localparam int CI_W   = BIN_W + 2;
    localparam int PROD_W = X_W + T_W;
    localparam int NUM_W  = PROD_W + BIN_W;
    localparam int DEN_W  = X_W + BIN_W;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [TID_W-1:0] LAST_TPL = TID_W'(TPL_NUM - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    bin_cnt;      // bins accepted so far; N once in CALC
    logic [CI_W-1:0]     calc_idx;     // cycle index inside one template pass
    logic [TID_W-1:0]    tpl_id;
    logic [DEN_W-1:0]    den;
    logic [NUM_W-1:0]    num;
    logic [PROD_W-1:0]   prod;
    logic                rd_valid;     // buffer/ROM data valid this cycle
    logic                prod_valid;   // prod register valid this cycle
    logic [X_W-1:0]      buf_rdata;
    logic [BIN_W-1:0]    buf_waddr;
    logic                bin_accept;
    logic                fill_done;
    logic                calc_done;
    logic                last_tpl;

    assign bin_ready  = (state == IDLE) || (state == FILL);
    assign bin_accept = bin_valid && bin_ready;
    assign fill_done  = bin_accept &&
                        (bin_last || ((state == FILL) && (bin_cnt == LAST_IDX)));
    // Last address goes out at N-1; its product lands in num at N+2.
    assign calc_done  = (state == CALC) && (calc_idx == CI_W'(bin_cnt) + CI_W'(2));
    assign last_tpl   = (tpl_id == LAST_TPL);
    // bin_cnt still holds the previous frame's N while in IDLE.
    assign buf_waddr  = (state == IDLE) ? '0 : bin_cnt[BIN_W-1:0];

    generate
        if (TPL_NUM > 1) begin : g_multi_tpl
            assign tpl_addr = {tpl_id, calc_idx[BIN_W-1:0]};
        end else begin : g_single_tpl
            assign tpl_addr = calc_idx[BIN_W-1:0];
        end
    endgenerate

    frame_buf_ram #(
        .DEPTH (FRAME_LEN),
        .W     (X_W)
    ) u_frame_buf (
        .clk   (clk),
        .we    (bin_accept),
        .waddr (buf_waddr),
        .wdata (bin_data),
        .raddr (calc_idx[BIN_W-1:0]),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bin_accept) state_nxt = bin_last ? CALC : FILL;
            FILL:    if (fill_done)  state_nxt = CALC;
            CALC:    if (calc_done)  state_nxt = ISSUE;
            ISSUE:   state_nxt = last_tpl ? IDLE : CALC;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bin_cnt      <= '0;
            calc_idx     <= '0;
            tpl_id       <= '0;
            den          <= '0;
            num          <= '0;
            prod         <= '0;
            rd_valid     <= 1'b0;
            prod_valid   <= 1'b0;
            div_valid    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            div_tpl_id   <= '0;
            frame_done   <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            rd_valid   <= (state == CALC) && (calc_idx < CI_W'(bin_cnt));
            prod_valid <= rd_valid;
            prod       <= PROD_W'(buf_rdata) * PROD_W'(tpl_data);
            div_valid  <= 1'b0;
            frame_done <= 1'b0;

            if (bin_valid && !bin_ready) begin
                err_overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bin_accept) begin
                        bin_cnt <= CNT_W'(1);
                        den     <= DEN_W'(bin_data);
                    end
                end
                FILL: begin
                    if (bin_accept) begin
                        bin_cnt <= bin_cnt + CNT_W'(1);
                        den     <= den + DEN_W'(bin_data);
                    end
                end
                CALC: begin
                    if (prod_valid) begin
                        num <= num + NUM_W'(prod);
                    end
                    if (calc_done) begin
                        // Outputs are loaded here so div_valid is high during ISSUE.
                        calc_idx   <= '0;
                        div_valid  <= 1'b1;
                        div_tpl_id <= tpl_id;
                        if (den == '0) begin
                            div_dividend <= '0;
                            div_divisor  <= D_W'(1);
                        end else begin
                            div_dividend <= I_W'(num);
                            div_divisor  <= D_W'(den);
                        end
                    end else begin
                        calc_idx <= calc_idx + CI_W'(1);
                    end
                end
                ISSUE: begin
                    num <= '0;
                    if (last_tpl) begin
                        tpl_id     <= '0;
                        frame_done <= 1'b1;
                    end else begin
                        tpl_id <= tpl_id + TID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_score_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_score_accum
//  Description : Self-checking bench. A small instance (8 bins, 2 templates)
//                covers directed and random frames, overrun and mid-frame
//                reset; a large instance (512 bins) covers full-scale widths.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_score_accum;

    localparam int FL  = 8;
    localparam int TN  = 2;
    localparam int BFL = 512;
    localparam int BTN = 2;

    typedef struct {
        longint unsigned dd;
        longint unsigned dv;
        int              id;
        int              cyc;
    } iss_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // small instance
    logic        bin_valid, bin_last, bin_ready;
    logic [15:0] bin_data;
    logic [3:0]  tpl_addr;
    logic [11:0] tpl_data;
    logic        div_valid, frame_done, err_overrun;
    logic [49:0] div_dividend;
    logic [37:0] div_divisor;
    logic [0:0]  div_tpl_id;

    // large instance
    logic        b_bin_valid, b_bin_last, b_bin_ready;
    logic [15:0] b_bin_data;
    logic [9:0]  b_tpl_addr;
    logic [11:0] b_tpl_data;
    logic        b_div_valid, b_frame_done, b_err_overrun;
    logic [49:0] b_div_dividend;
    logic [37:0] b_div_divisor;
    logic [0:0]  b_div_tpl_id;

    audio_score_accum #(.FRAME_LEN(FL), .TPL_NUM(TN)) dut (
        .clk(clk), .reset(reset),
        .bin_valid(bin_valid), .bin_data(bin_data), .bin_last(bin_last),
        .bin_ready(bin_ready), .tpl_addr(tpl_addr), .tpl_data(tpl_data),
        .div_valid(div_valid), .div_dividend(div_dividend),
        .div_divisor(div_divisor), .div_tpl_id(div_tpl_id),
        .frame_done(frame_done), .err_overrun(err_overrun)
    );

    audio_score_accum #(.FRAME_LEN(BFL), .TPL_NUM(BTN)) dut_big (
        .clk(clk), .reset(reset),
        .bin_valid(b_bin_valid), .bin_data(b_bin_data), .bin_last(b_bin_last),
        .bin_ready(b_bin_ready), .tpl_addr(b_tpl_addr), .tpl_data(b_tpl_data),
        .div_valid(b_div_valid), .div_dividend(b_div_dividend),
        .div_divisor(b_div_divisor), .div_tpl_id(b_div_tpl_id),
        .frame_done(b_frame_done), .err_overrun(b_err_overrun)
    );

    // template ROMs, 1-cycle read latency
    logic [11:0] rom   [FL*TN];
    logic [11:0] b_rom [BFL*BTN];
    always @(posedge clk) tpl_data   <= rom[tpl_addr];
    always @(posedge clk) b_tpl_data <= b_rom[b_tpl_addr];

    // monitors
    int   cyc = 0;
    iss_t iss_q[$];
    iss_t b_iss_q[$];
    int   fd_cnt = 0, fd_cyc = 0, b_fd_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (div_valid)
            iss_q.push_back('{longint'(div_dividend), longint'(div_divisor), int'(div_tpl_id), cyc});
        if (b_div_valid)
            b_iss_q.push_back('{longint'(b_div_dividend), longint'(b_div_divisor), int'(b_div_tpl_id), cyc});
        if (frame_done) begin
            fd_cnt <= fd_cnt + 1;
            fd_cyc <= cyc;
        end
        if (b_frame_done) b_fd_cnt <= b_fd_cnt + 1;
    end

    int n_cmp = 0, n_fail = 0;
    int iss_seen = 0, fd_seen = 0;
    logic [15:0] xs [FL];

    // reference model: plain weighted sums over the bins actually received
    function automatic longint unsigned model_num(input int k, input int n);
        longint unsigned s = 0;
        for (int i = 0; i < n; i++) s += longint'(xs[i]) * longint'(rom[k*FL + i]);
        return s;
    endfunction

    function automatic longint unsigned model_den(input int n);
        longint unsigned s = 0;
        for (int i = 0; i < n; i++) s += longint'(xs[i]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bins(input int n, input bit use_last, input int gap_max);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) tick();
            bin_valid = 1'b1;
            bin_data  = xs[i];
            bin_last  = use_last && (i == n - 1);
            tick();
            bin_valid = 1'b0;
            bin_last  = 1'b0;
        end
    endtask

    task automatic check_frame(input int n, input string tag);
        int waited = 0;
        longint unsigned en, ed;
        iss_t e;
        while (fd_cnt == fd_seen && waited < 400) begin
            tick();
            waited++;
        end
        repeat (3) tick();
        n_cmp++;
        if (fd_cnt - fd_seen != 1) begin
            n_fail++;
            $display("FAIL %s frame_done pulses: got %0d want 1", tag, fd_cnt - fd_seen);
        end
        n_cmp++;
        if (iss_q.size() - iss_seen != TN) begin
            n_fail++;
            $display("FAIL %s issue count: got %0d want %0d", tag, iss_q.size() - iss_seen, TN);
        end else begin
            for (int k = 0; k < TN; k++) begin
                e  = iss_q[iss_seen + k];
                en = model_num(k, n);
                ed = model_den(n);
                if (ed == 0) begin
                    en = 0;
                    ed = 1;
                end
                n_cmp++;
                if (e.id != k) begin
                    n_fail++;
                    $display("FAIL %s tpl_id[%0d]: got %0d want %0d", tag, k, e.id, k);
                end
                n_cmp++;
                if (e.dd != en) begin
                    n_fail++;
                    $display("FAIL %s dividend[%0d]: got %0d want %0d", tag, k, e.dd, en);
                end
                n_cmp++;
                if (e.dv != ed) begin
                    n_fail++;
                    $display("FAIL %s divisor[%0d]: got %0d want %0d", tag, k, e.dv, ed);
                end
                if (k > 0) begin
                    n_cmp++;
                    if (e.cyc - iss_q[iss_seen + k - 1].cyc != n + 4) begin
                        n_fail++;
                        $display("FAIL %s issue spacing: got %0d want %0d", tag,
                                 e.cyc - iss_q[iss_seen + k - 1].cyc, n + 4);
                    end
                end
            end
            n_cmp++;
            if (fd_cyc != iss_q[iss_seen + TN - 1].cyc + 1) begin
                n_fail++;
                $display("FAIL %s frame_done timing: got cycle %0d want %0d", tag,
                         fd_cyc, iss_q[iss_seen + TN - 1].cyc + 1);
            end
        end
        iss_seen = iss_q.size();
        fd_seen  = fd_cnt;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if ({div_valid, frame_done, err_overrun, div_tpl_id, tpl_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset ctrl outs: got %b want 0",
                     {div_valid, frame_done, err_overrun, div_tpl_id, tpl_addr});
        end
        n_cmp++;
        if (div_dividend !== '0 || div_divisor !== '0) begin
            n_fail++;
            $display("FAIL reset data outs: got %0d/%0d want 0/0", div_dividend, div_divisor);
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (bin_ready !== 1'b1 || b_bin_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset bin_ready: got %b%b want 11", bin_ready, b_bin_ready);
        end
    endtask

    task automatic test_directed();
        // all ones against a full-scale and an all-zero template
        for (int i = 0; i < FL; i++) begin
            xs[i] = 16'd1;
            rom[i] = 12'd4095;
            rom[FL + i] = 12'd0;
        end
        send_bins(FL, 1'b1, 0);
        check_frame(FL, "ones");
        n_cmp++;
        if (iss_q[iss_seen-2].dd != 64'd32760 || iss_q[iss_seen-2].dv != 64'd8) begin
            n_fail++;
            $display("FAIL ones T0 word: got %0d/%0d want 32760/8",
                     iss_q[iss_seen-2].dd, iss_q[iss_seen-2].dv);
        end
        // silent frame forces the 0/1 word, frame ends on length
        for (int i = 0; i < FL; i++) xs[i] = 16'd0;
        send_bins(FL, 1'b0, 1);
        check_frame(FL, "zeros");
        // short frame ended by bin_last
        xs[0] = 16'd2; xs[1] = 16'd4; xs[2] = 16'd6;
        for (int i = 0; i < FL; i++) rom[i] = 12'd1000;
        send_bins(3, 1'b1, 0);
        check_frame(3, "short");
        n_cmp++;
        if (iss_q[iss_seen-2].dd != 64'd12000 || iss_q[iss_seen-2].dv != 64'd12) begin
            n_fail++;
            $display("FAIL short T0 word: got %0d/%0d want 12000/12",
                     iss_q[iss_seen-2].dd, iss_q[iss_seen-2].dv);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < FL; i++) begin
            xs[i] = 16'd1;
            rom[i] = 12'd4095;
            rom[FL + i] = 12'd0;
        end
        send_bins(FL, 1'b0, 0);
        repeat (2) tick();
        n_cmp++;
        if (bin_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun bin_ready in CALC: got %b want 0", bin_ready);
        end
        bin_valid = 1'b1;
        bin_data  = 16'hFFFF;
        bin_last  = 1'b1;
        tick();
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun flag: got %b want 1", err_overrun);
        end
        #1;
        check_frame(FL, "overrun");
        n_cmp++;
        if (err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun sticky: got %b want 1", err_overrun);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < FL; i++) xs[i] = 16'($urandom_range(1, 65535));
        send_bins(FL, 1'b1, 0);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({div_valid, frame_done, err_overrun, bin_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset outs: got %b want 0001",
                     {div_valid, frame_done, err_overrun, bin_ready});
        end
        n_cmp++;
        if (div_dividend !== '0 || div_divisor !== '0) begin
            n_fail++;
            $display("FAIL midreset data: got %0d/%0d want 0/0", div_dividend, div_divisor);
        end
        repeat (2) tick();
        reset = 1'b1;
        repeat (40) tick();
        n_cmp++;
        if (iss_q.size() != iss_seen || fd_cnt != fd_seen) begin
            n_fail++;
            $display("FAIL midreset stray issue: got %0d issues %0d done want 0 0",
                     iss_q.size() - iss_seen, fd_cnt - fd_seen);
        end
        iss_seen = iss_q.size();
        fd_seen  = fd_cnt;
        for (int i = 0; i < FL * TN; i++) rom[i] = 12'($urandom);
        send_bins(FL, 1'b1, 2);
        check_frame(FL, "after_reset");
    endtask

    task automatic test_random();
        int n;
        bit use_last;
        for (int f = 0; f < 8; f++) begin
            n = (f == 0) ? 1 : int'($urandom_range(1, FL));
            use_last = (n < FL) ? 1'b1 : 1'($urandom_range(0, 1));
            for (int i = 0; i < FL; i++) xs[i] = 16'($urandom);
            for (int i = 0; i < FL * TN; i++)
                rom[i] = ($urandom_range(0, 3) == 0) ? 12'd4095 : 12'($urandom);
            send_bins(n, use_last, 2);
            check_frame(n, "random");
        end
    endtask

    task automatic test_full_scale();
        int waited = 0;
        for (int i = 0; i < BFL * BTN; i++) b_rom[i] = 12'd4095;
        for (int i = 0; i < BFL; i++) begin
            b_bin_valid = 1'b1;
            b_bin_data  = 16'hFFFF;
            tick();
        end
        b_bin_valid = 1'b0;
        while (b_fd_cnt == 0 && waited < 3000) begin
            tick();
            waited++;
        end
        repeat (3) tick();
        n_cmp++;
        if (b_fd_cnt != 1 || b_iss_q.size() != BTN) begin
            n_fail++;
            $display("FAIL big counts: got %0d done %0d issues want 1 %0d",
                     b_fd_cnt, b_iss_q.size(), BTN);
        end else begin
            for (int k = 0; k < BTN; k++) begin
                n_cmp++;
                if (b_iss_q[k].dd != 64'd137403302400 || b_iss_q[k].dv != 64'd33553920 ||
                    b_iss_q[k].id != k) begin
                    n_fail++;
                    $display("FAIL big word[%0d]: got %0d/%0d id %0d want 137403302400/33553920 id %0d",
                             k, b_iss_q[k].dd, b_iss_q[k].dv, b_iss_q[k].id, k);
                end
            end
            n_cmp++;
            if (b_iss_q[1].cyc - b_iss_q[0].cyc != BFL + 4) begin
                n_fail++;
                $display("FAIL big spacing: got %0d want %0d",
                         b_iss_q[1].cyc - b_iss_q[0].cyc, BFL + 4);
            end
        end
        n_cmp++;
        if (b_err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL big overrun flag: got %b want 0", b_err_overrun);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bin_valid = 1'b0; bin_last = 1'b0; bin_data = '0;
        b_bin_valid = 1'b0; b_bin_last = 1'b0; b_bin_data = '0;
        for (int i = 0; i < FL * TN; i++) rom[i] = '0;
        for (int i = 0; i < BFL * BTN; i++) b_rom[i] = '0;
        test_reset();
        test_directed();
        test_overrun();
        test_reset_mid();
        test_random();
        test_full_scale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
